ddr3_app_master: RTL and testbench
==================================

# ddr3_app_master

Initiator on the user side of the Gowin DDR3 Memory Interface IP application port. Takes single-beat read/write requests from a simple valid/ready request port and issues them as BL8 commands (one 128-bit beat each) to the IP, returning one response per request. Sits between the SoC memory fabric and `DDR3_Memory_Interface_Top`, clocked by the IP's `clk_out` (memory_clk/4) domain.

## Interface
- `ADDR_W`, 28, IP `addr` width (rank bit included)
- `DATA_W`, 128, app data width; mask width is `DATA_W/8`
- `TIMEOUT_CYC`, 1024, read watchdog limit in cycles (used only with the macro)

- `clk` in 1: application clock (IP `clk_out`)
- `rst` in 1: reset, asynchronous, active-high
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when both high
- `req_we` in 1: 1 = write, 0 = read
- `req_addr` in ADDR_W: IP address; bits [2:0] forced to 0 on issue
- `req_wdata` in DATA_W: write data
- `req_wstrb` in DATA_W/8: byte enables, 1 = write byte
- `resp_valid` out 1: one-cycle response pulse
- `resp_rdata` out DATA_W: read data, held until next read response
- `resp_err` out 1: qualified by `resp_valid`; read timed out
- `init_calib_complete` in 1: IP calibration done
- `app_burst_number` out 6: constant 0
- `cmd_ready` in 1, `cmd` out 3, `cmd_en` out 1, `addr` out ADDR_W: IP command channel
- `wr_data_rdy` in 1, `wr_data` out DATA_W, `wr_data_en` out 1, `wr_data_end` out 1, `wr_data_mask` out DATA_W/8: IP write channel
- `rd_data` in DATA_W, `rd_data_valid` in 1, `rd_data_end` in 1: IP read channel

## Operation
- States: INIT, IDLE, WR, RD_CMD, RD_WAIT, RESP.
- INIT -> IDLE when `init_calib_complete`=1. IDLE -> INIT when it drops; calibration is not checked in any other state.
- `req_ready` = (state==IDLE) && `init_calib_complete`. On acceptance, register addr/data/mask/we. Go to WR if `req_we`, else RD_CMD.
- WR: `cmd_en`=`wr_data_en`=`wr_data_end`=1 combinationally in the cycle where `cmd_ready`&&`wr_data_rdy`. `cmd`=3'd0, `wr_data_mask`=~stored strobe (1 = masked). Then go to RESP.
- RD_CMD: `cmd_en`=1 when `cmd_ready`, `cmd`=3'd1, then go to RD_WAIT.
- RD_WAIT: on `rd_data_valid`, capture `rd_data` into `resp_rdata` and go to RESP. `rd_data_end` is not required; with a single beat it coincides with valid.
- RESP: `resp_valid`=1 for one cycle (`resp_err` as set), then IDLE.
- `rd_data_valid` outside RD_WAIT is ignored.
- `cmd` and `addr` are driven from registers and are stable while `cmd_en` is low. `addr[2:0]`=0.
- Reset value of every output is 0, except `wr_data_mask`, which resets to all 1s. State after reset is INIT. Reset mid-transaction drops the request with no response.

## Timing
- Write best case: accepted cycle 0, `cmd_en`/`wr_data_en` at cycle 1, `resp_valid` at cycle 2.
- Read: accepted cycle 0, `cmd_en` at cycle 1, `rd_data_valid` at cycle N, `resp_valid` plus data at N+1.
- One outstanding request at a time. `req_ready` is low from acceptance until the cycle after `resp_valid`, so the next acceptance is earliest at RESP+1.
- Stalls on `cmd_ready`/`wr_data_rdy` are unbounded. The IP enable outputs never assert while the IP's ready input is low.

## Configuration
- `DDR3_APP_TIMEOUT_EN` defined: a counter clears on entering RD_WAIT and increments each cycle there. When it reaches `TIMEOUT_CYC` with no `rd_data_valid`, go to RESP with `resp_err`=1 and `resp_rdata` unchanged. A later stray `rd_data_valid` is ignored.
- Not defined: no counter, `resp_err` tied 0, RD_WAIT waits indefinitely.

## Structure
- Package `ddr3_app_pkg`: `CMD_WR`=3'd0, `CMD_RD`=3'd1, state enum, default widths.
- One sub-module `ddr3_app_watchdog` (counter plus expiry flag, parameter `TIMEOUT_CYC`). It is instantiated only under `DDR3_APP_TIMEOUT_EN`.

## Test plan
- Calib gating: hold `init_calib_complete`=0 for 50 cycles with `req_valid`=1 -> `req_ready`=0 and no `cmd_en`. Raise calib -> accepted in the next cycle.
- Write: addr 0x0000_123, data 0x0123…CDEF, strobe 0x00FF, `cmd_ready`=`wr_data_rdy`=1 -> at cycle 1 `cmd`=0, `addr`=0x0000_120, `wr_data_mask`=0xFF00, end=1; `resp_valid` at cycle 2.
- Read backpressure: `cmd_ready`=0 for 7 cycles -> `cmd_en` low throughout and asserts on the first ready cycle with `cmd`=1. `rd_data_valid` 20 cycles later with 0xA5…A5 -> `resp_rdata`=0xA5…A5, `resp_err`=0.
- Write stall: `cmd_ready`=1, `wr_data_rdy`=0 for 5 cycles -> no `cmd_en`/`wr_data_en` until both ready, then both pulse together for exactly 1 cycle.
- Timeout (macro on, `TIMEOUT_CYC`=16): read with no `rd_data_valid` -> `resp_valid` with `resp_err`=1 at 16 cycles after RD_WAIT entry. A stray valid afterwards produces no response.
- Async reset during RD_WAIT -> all outputs 0 immediately, `wr_data_mask` all 1s, state INIT, no `resp_valid` after release.

Source files
------------

// File: rtl/ddr3_app_pkg.sv
// Shared command codes, FSM state type and default widths for the DDR3 application-port master.
package ddr3_app_pkg;

    localparam int unsigned ADDR_W_DEF      = 28;
    localparam int unsigned DATA_W_DEF      = 128;
    localparam int unsigned TIMEOUT_CYC_DEF = 1024;

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR,
        RD_CMD,
        RD_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/ddr3_app_watchdog.sv
// Read-wait watchdog: counts cycles spent waiting for read data and flags expiry.
module ddr3_app_watchdog
    import ddr3_app_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;

    // count holds the number of earlier wait cycles, so expiry fires in the TIMEOUT_CYC-th cycle
    assign expired = run && (count == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ddr3_app_master.sv
// Single-beat BL8 initiator for the Gowin DDR3 IP application port.
// Optional read watchdog enabled by defining DDR3_APP_TIMEOUT_EN.
module ddr3_app_master
    import ddr3_app_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    input  logic                init_calib_complete,
    output logic [5:0]          app_burst_number,
    input  logic                cmd_ready,
    output logic [2:0]          cmd,
    output logic                cmd_en,
    output logic [ADDR_W-1:0]   addr,
    input  logic                wr_data_rdy,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_data_en,
    output logic                wr_data_end,
    output logic [DATA_W/8-1:0] wr_data_mask,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_data_valid,
    input  logic                rd_data_end
);

    state_t state;
    logic   wr_fire;
    logic   rd_fire;
    logic   rd_expired;
    logic   unused_inputs;

    // Single beat per command: rd_data_end always coincides with valid and the low address bits are overridden
    assign unused_inputs = ^{rd_data_end, req_addr[2:0]};

    assign app_burst_number = '0;
    assign req_ready        = (state == IDLE) && init_calib_complete;

    // Enables are combinational so they can never assert while the IP is not ready
    assign wr_fire     = (state == WR) && cmd_ready && wr_data_rdy;
    assign rd_fire     = (state == RD_CMD) && cmd_ready;
    assign cmd_en      = wr_fire || rd_fire;
    assign wr_data_en  = wr_fire;
    assign wr_data_end = wr_fire;

`ifdef DDR3_APP_TIMEOUT_EN
    ddr3_app_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (rd_fire),
        .run     (state == RD_WAIT),
        .expired (rd_expired)
    );
`else
    assign rd_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= INIT;
            cmd          <= '0;
            addr         <= '0;
            wr_data      <= '0;
            wr_data_mask <= '1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                INIT: begin
                    if (init_calib_complete) state <= IDLE;
                end
                IDLE: begin
                    if (!init_calib_complete) begin
                        state <= INIT;
                    end else if (req_valid) begin
                        addr <= {req_addr[ADDR_W-1:3], 3'b000};
                        if (req_we) begin
                            cmd          <= CMD_WR;
                            wr_data      <= req_wdata;
                            wr_data_mask <= ~req_wstrb;
                            state        <= WR;
                        end else begin
                            cmd   <= CMD_RD;
                            state <= RD_CMD;
                        end
                    end
                end
                WR: begin
                    if (wr_fire) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end
                end
                RD_CMD: begin
                    if (cmd_ready) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rd_data_valid) begin
                        resp_rdata <= rd_data;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end else if (rd_expired) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_app_master.sv
// Self-checking bench for ddr3_app_master: the bench plays the DDR3 IP and checks every transaction
// against latencies and data predicted from the request/stall parameters.
module tb_ddr3_app_master;

    localparam int unsigned TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [27:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_wstrb;
    logic         resp_valid;
    logic [127:0] resp_rdata;
    logic         resp_err;
    logic         init_calib_complete;
    logic [5:0]   app_burst_number;
    logic         cmd_ready;
    logic [2:0]   cmd;
    logic         cmd_en;
    logic [27:0]  addr;
    logic         wr_data_rdy;
    logic [127:0] wr_data;
    logic         wr_data_en;
    logic         wr_data_end;
    logic [15:0]  wr_data_mask;
    logic [127:0] rd_data;
    logic         rd_data_valid;
    logic         rd_data_end;

    int unsigned  checks   = 0;
    int unsigned  failures = 0;
    logic [127:0] last_rdata = '0;

    ddr3_app_master #(
        .ADDR_W      (28),
        .DATA_W      (128),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_we              (req_we),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_wstrb           (req_wstrb),
        .resp_valid          (resp_valid),
        .resp_rdata          (resp_rdata),
        .resp_err            (resp_err),
        .init_calib_complete (init_calib_complete),
        .app_burst_number    (app_burst_number),
        .cmd_ready           (cmd_ready),
        .cmd                 (cmd),
        .cmd_en              (cmd_en),
        .addr                (addr),
        .wr_data_rdy         (wr_data_rdy),
        .wr_data             (wr_data),
        .wr_data_en          (wr_data_en),
        .wr_data_end         (wr_data_end),
        .wr_data_mask        (wr_data_mask),
        .rd_data             (rd_data),
        .rd_data_valid       (rd_data_valid),
        .rd_data_end         (rd_data_end)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one request and plays the IP; stalls are counted in cycles after acceptance (cycle 0).
    // rlat = 0 means read data never arrives.
    task automatic do_txn(input bit we, input logic [27:0] a, input logic [127:0] d,
                          input logic [15:0] s, input int unsigned cstall,
                          input int unsigned wstall, input int unsigned rlat,
                          input bit expect_timeout);
        int unsigned  issue_c = 0;
        int unsigned  resp_c  = 0;
        int unsigned  en_cnt  = 0;
        int unsigned  exp_issue;
        int unsigned  exp_resp;
        int unsigned  budget;
        logic [127:0] rdat;
        logic [127:0] exp_rdata;
        rdat      = rand128();
        exp_rdata = (we || expect_timeout) ? last_rdata : rdat;
        budget    = cstall + wstall + rlat + TO + 10;
        @(negedge clk);
        req_valid     = 1'b1;
        req_we        = we;
        req_addr      = a;
        req_wdata     = d;
        req_wstrb     = s;
        cmd_ready     = 1'(($urandom));
        wr_data_rdy   = 1'(($urandom));
        rd_data_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || cmd_en !== 1'b0) begin
            $display("FAIL accept: req_ready=%b resp_valid=%b cmd_en=%b, required 1 0 0",
                     req_ready, resp_valid, cmd_en);
            failures++;
            @(negedge clk);
            req_valid = 1'b0;
            return;
        end
        for (int unsigned c = 1; c <= budget; c++) begin
            @(negedge clk);
            req_valid     = 1'b0;
            req_addr      = 28'($urandom);
            req_wdata     = rand128();
            req_wstrb     = 16'($urandom);
            cmd_ready     = (c > cstall);
            wr_data_rdy   = we ? (c > wstall) : 1'(($urandom));
            rd_data_valid = 1'b0;
            rd_data       = rand128();
            if (!we) begin
                if (issue_c == 0 && c == 1 && cstall > 0) begin
                    rd_data_valid = 1'b1;
                    rd_data       = ~rdat;
                end else if (issue_c != 0 && rlat != 0 && c == issue_c + rlat) begin
                    rd_data_valid = 1'b1;
                    rd_data       = rdat;
                end
            end
            #1;
            checks++;
            if ((cmd_en && !cmd_ready) || (wr_data_en && !wr_data_rdy) || req_ready !== 1'b0
                || wr_data_en !== wr_data_end || (!we && wr_data_en)) begin
                $display("FAIL handshake c=%0d: cmd_en=%b cmd_ready=%b wr_en=%b wr_end=%b wr_rdy=%b req_ready=%b",
                         c, cmd_en, cmd_ready, wr_data_en, wr_data_end, wr_data_rdy, req_ready);
                failures++;
            end
            if (cmd_en === 1'b1) begin
                en_cnt++;
                if (issue_c == 0) issue_c = c;
                checks++;
                if (cmd !== (we ? 3'd0 : 3'd1) || addr !== {a[27:3], 3'b000}) begin
                    $display("FAIL cmd: cmd=%0d addr=%h, required cmd=%0d addr=%h",
                             cmd, addr, we ? 0 : 1, {a[27:3], 3'b000});
                    failures++;
                end
                if (we) begin
                    checks++;
                    if (wr_data_en !== 1'b1 || wr_data !== d || wr_data_mask !== ~s) begin
                        $display("FAIL wdata: en=%b data=%h mask=%h, required 1 %h %h",
                                 wr_data_en, wr_data, wr_data_mask, d, ~s);
                        failures++;
                    end
                end
            end
            if (resp_valid === 1'b1) begin
                resp_c = c;
                checks++;
                if (resp_err !== expect_timeout || resp_rdata !== exp_rdata) begin
                    $display("FAIL resp: err=%b rdata=%h, required %b %h",
                             resp_err, resp_rdata, expect_timeout, exp_rdata);
                    failures++;
                end
                break;
            end
        end
        exp_issue = we ? ((cstall > wstall ? cstall : wstall) + 1) : (cstall + 1);
        exp_resp  = we ? exp_issue + 1 : (expect_timeout ? exp_issue + 1 + TO : exp_issue + rlat + 1);
        checks++;
        if (issue_c != exp_issue || resp_c != exp_resp || en_cnt != 1) begin
            $display("FAIL timing: issue=%0d resp=%0d pulses=%0d, required %0d %0d 1",
                     issue_c, resp_c, en_cnt, exp_issue, exp_resp);
            failures++;
        end
        if (!we && !expect_timeout) last_rdata = rdat;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || cmd_en !== 1'b0
            || wr_data_en !== 1'b0 || wr_data_end !== 1'b0 || cmd !== 3'd0 || addr !== 28'd0
            || wr_data !== 128'd0 || resp_rdata !== 128'd0 || app_burst_number !== 6'd0
            || wr_data_mask !== 16'hFFFF) begin
            $display("FAIL %s: rdy=%b rv=%b err=%b en=%b wen=%b wend=%b cmd=%0d addr=%h wd=%h rd=%h bn=%0d mask=%h, required zeros and mask=ffff",
                     tag, req_ready, resp_valid, resp_err, cmd_en, wr_data_en, wr_data_end,
                     cmd, addr, wr_data, resp_rdata, app_burst_number, wr_data_mask);
            failures++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_calib_complete = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        cmd_ready = 1'b0; wr_data_rdy = 1'b0;
        rd_data = '0; rd_data_valid = 1'b0; rd_data_end = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_calib_gating();
        req_valid = 1'b1;
        req_we    = 1'b1;
        cmd_ready = 1'b1;
        wr_data_rdy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (req_ready !== 1'b0 || cmd_en !== 1'b0) begin
                $display("FAIL calib_gate: req_ready=%b cmd_en=%b, required 0 0", req_ready, cmd_en);
                failures++;
            end
        end
        @(negedge clk);
        init_calib_complete = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            $display("FAIL calib_rise: req_ready=%b, required 0", req_ready);
            failures++;
        end
        do_txn(1'b1, 28'h0000555, rand128(), 16'hFFFF, 0, 0, 0, 1'b0);
    endtask

    task automatic test_write();
        do_txn(1'b1, 28'h0000123, 128'h0123456789ABCDEF0123456789ABCDEF, 16'h00FF, 0, 0, 0, 1'b0);
    endtask

    task automatic test_read_backpressure();
        int unsigned n0;
        n0 = failures;
        do_txn(1'b0, 28'h0ABCDEF, rand128(), 16'h0, 7, 0, 20, 1'b0);
        // model-level confirmation that the captured pattern is the one the IP returned
        checks++;
        if (failures == n0 && resp_rdata !== last_rdata) begin
            $display("FAIL rd_hold: rdata=%h, required %h", resp_rdata, last_rdata);
            failures++;
        end
    endtask

    task automatic test_write_stall();
        do_txn(1'b1, 28'hFFFFFFF, rand128(), 16'hA5A5, 0, 5, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            do_txn(1'(($urandom)), 28'($urandom), rand128(), 16'($urandom),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 6), 1'b0);
        end
    endtask

    task automatic test_timeout();
`ifdef DDR3_APP_TIMEOUT_EN
        do_txn(1'b0, 28'h0000040, rand128(), 16'h0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_data_valid = (i < 2);
            rd_data       = rand128();
            #1;
            checks++;
            if (resp_valid !== 1'b0 || resp_rdata !== last_rdata) begin
                $display("FAIL stray_valid: resp_valid=%b rdata=%h, required 0 %h",
                         resp_valid, resp_rdata, last_rdata);
                failures++;
            end
        end
        rd_data_valid = 1'b0;
`endif
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h1234568; cmd_ready = 1'b1;
        rd_data_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        cmd_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd_data_valid = 1'b1;
        rd_data = rand128();
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            $display("FAIL post_reset_init: req_ready=%b, required 0", req_ready);
            failures++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd_data_valid = (i < 4);
            #1;
            checks++;
            if (resp_valid !== 1'b0) begin
                $display("FAIL post_reset_resp: resp_valid=%b, required 0", resp_valid);
                failures++;
            end
        end
        rd_data_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL post_reset_idle: req_ready=%b, required 1", req_ready);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_calib_gating();
        test_write();
        test_read_backpressure();
        test_write_stall();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
